// File: rtl/ec_pipe_sched.sv
// rtl/ec_pipe_sched.sv - round-robin scheduler sharing one error-correcting pipe among requesters
// Tags ride a delay line matched to the pipe latency so each corrected word returns to its owner.
module ec_pipe_sched #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int DATA_WIDTH  = 18,
    parameter int NDIG        = 10,
    parameter int PIPE_LAT    = 86,
    parameter int LOCK_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            aclr,
    input  logic                            en,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*NDIG*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]                 req_ready,
    output logic                            pipe_dval,
    output logic [NDIG*DATA_WIDTH-1:0]      pipe_dig,
    input  logic                            pipe_dval_out,
    input  logic [NDIG*DATA_WIDTH-1:0]      pipe_out,
    input  logic                            pipe_cor,
    input  logic                            pipe_noncor,
    input  logic                            pipe_mal,
    input  logic [2*NDIG-1:0]               pipe_errdigs,
    output logic                            rsp_valid,
    output logic [IDW-1:0]                  rsp_id,
    output logic [NDIG*DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                      rsp_status,
    output logic [2*NDIG-1:0]               rsp_errdigs,
    output logic [NREQ-1:0]                 locked,
    input  logic [NREQ-1:0]                 lock_clr,
    output logic [CNT_W-1:0]                cnt_cor,
    output logic [CNT_W-1:0]                cnt_noncor,
    output logic [CNT_W-1:0]                cnt_mal,
    input  logic                            cnt_clr,
    output logic                            busy,
    output logic                            sync_err
);
    localparam int WW  = NDIG*DATA_WIDTH;
    localparam int TW  = IDW + 1;
    localparam int BCW = $clog2(LOCK_THRESH+1);

    logic [IDW-1:0]             rr_q, rr_d;
    logic                       pipe_dval_q, pipe_dval_d;
    logic [WW-1:0]              pipe_dig_q, pipe_dig_d;
    logic [IDW-1:0]             pipe_id_q, pipe_id_d;
    logic [PIPE_LAT*TW-1:0]     tag_q, tag_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]             rsp_id_q, rsp_id_d;
    logic [WW-1:0]              rsp_data_q, rsp_data_d;
    logic [1:0]                 rsp_status_q, rsp_status_d;
    logic [2*NDIG-1:0]          rsp_errdigs_q, rsp_errdigs_d;
    logic                       sync_err_q, sync_err_d;
    logic [NREQ-1:0]            locked_q, locked_d;
    logic [NREQ-1:0][BCW-1:0]   bad_q, bad_d;
    logic [CNT_W-1:0]           cnt_cor_q, cnt_cor_d;
    logic [CNT_W-1:0]           cnt_noncor_q, cnt_noncor_d;
    logic [CNT_W-1:0]           cnt_mal_q, cnt_mal_d;

    logic [NREQ-1:0]            elig;
    logic                       grant_vld;
    logic [IDW-1:0]             grant_id;
    int                         j;
    logic                       tail_vld;
    logic [IDW-1:0]             tail_id;
    logic [1:0]                 status;
    logic                       busy_c;

    // Search starts at rr and wraps; the first eligible requester wins.
    always_comb begin
        elig      = req_valid & ~locked_q & {NREQ{en}};
        grant_vld = 1'b0;
        grant_id  = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_vld && elig[IDW'(j)]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(j);
            end
        end
        req_ready = '0;
        if (grant_vld) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        rr_d        = rr_q;
        pipe_dval_d = grant_vld;
        pipe_dig_d  = pipe_dig_q;
        pipe_id_d   = pipe_id_q;
        if (grant_vld) begin
            rr_d      = (int'(grant_id) == NREQ-1) ? '0 : grant_id + 1'b1;
            pipe_id_d = grant_id;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vld && grant_id == IDW'(i)) pipe_dig_d = req_data[i*WW +: WW];
        end
    end

    // The tag tail lines up with pipe_dval_out because both are fed by pipe_dval.
    always_comb begin
        tag_d    = {tag_q[(PIPE_LAT-1)*TW-1:0], pipe_dval_q, pipe_id_q};
        tail_vld = tag_q[PIPE_LAT*TW-1];
        tail_id  = tag_q[PIPE_LAT*TW-2 -: IDW];
        busy_c   = pipe_dval_q;
        for (int k = 0; k < PIPE_LAT; k++) busy_c = busy_c | tag_q[k*TW+IDW];
    end

    always_comb begin
        if (pipe_mal)         status = 2'b11;
        else if (pipe_noncor) status = 2'b10;
        else if (pipe_cor)    status = 2'b01;
        else                  status = 2'b00;
        rsp_valid_d   = pipe_dval_out;
        rsp_id_d      = tail_id;
        rsp_data_d    = pipe_out;
        rsp_status_d  = status;
        rsp_errdigs_d = pipe_errdigs;
        sync_err_d    = sync_err_q | (pipe_dval_out != tail_vld);
    end

    // Lockout counts consecutive bad results per owner; lock_clr overrides any update.
    always_comb begin
        bad_d    = bad_q;
        locked_d = locked_q;
        for (int i = 0; i < NREQ; i++) begin
            if (pipe_dval_out && tail_id == IDW'(i)) begin
                if (status[1]) begin
                    if (bad_q[i] != BCW'(LOCK_THRESH)) bad_d[i] = bad_q[i] + 1'b1;
                    if (bad_d[i] == BCW'(LOCK_THRESH)) locked_d[i] = 1'b1;
                end else begin
                    bad_d[i] = '0;
                end
            end
            if (lock_clr[i]) begin
                bad_d[i]    = '0;
                locked_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_cor_d    = cnt_cor_q;
        cnt_noncor_d = cnt_noncor_q;
        cnt_mal_d    = cnt_mal_q;
        if (pipe_dval_out) begin
            if (status == 2'b01 && cnt_cor_q != '1)    cnt_cor_d    = cnt_cor_q + 1'b1;
            if (status == 2'b10 && cnt_noncor_q != '1) cnt_noncor_d = cnt_noncor_q + 1'b1;
            if (status == 2'b11 && cnt_mal_q != '1)    cnt_mal_d    = cnt_mal_q + 1'b1;
        end
        if (cnt_clr) begin
            cnt_cor_d    = '0;
            cnt_noncor_d = '0;
            cnt_mal_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rr_q          <= '0;
            pipe_dval_q   <= 1'b0;
            pipe_dig_q    <= '0;
            pipe_id_q     <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_errdigs_q <= '0;
            sync_err_q    <= 1'b0;
            locked_q      <= '0;
            bad_q         <= '0;
            cnt_cor_q     <= '0;
            cnt_noncor_q  <= '0;
            cnt_mal_q     <= '0;
        end else begin
            rr_q          <= rr_d;
            pipe_dval_q   <= pipe_dval_d;
            pipe_dig_q    <= pipe_dig_d;
            pipe_id_q     <= pipe_id_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_errdigs_q <= rsp_errdigs_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
            bad_q         <= bad_d;
            cnt_cor_q     <= cnt_cor_d;
            cnt_noncor_q  <= cnt_noncor_d;
            cnt_mal_q     <= cnt_mal_d;
        end
    end

    assign pipe_dval   = pipe_dval_q;
    assign pipe_dig    = pipe_dig_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_errdigs = rsp_errdigs_q;
    assign locked      = locked_q;
    assign cnt_cor     = cnt_cor_q;
    assign cnt_noncor  = cnt_noncor_q;
    assign cnt_mal     = cnt_mal_q;
    assign busy        = busy_c;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_ec_pipe_sched.sv
// tb/tb_ec_pipe_sched.sv - scoreboard bench for ec_pipe_sched with a behavioural correction pipe
// Each digit's MSB marks it corrupted; the pipe model flags 1 as corrected, 2 non-correctable, 3+ malicious.
module tb_ec_pipe_sched;
    localparam int NREQ = 4, IDW = 2, DW = 18, NDIG = 10, PIPE_LAT = 86, TH = 3, CNT_W = 4;
    localparam int WW = NDIG*DW;

    typedef struct packed {
        logic [WW-1:0]     data;
        logic [1:0]        st;
        logic [2*NDIG-1:0] ed;
        logic [3:0]        n;
    } pres_t;
    typedef struct {
        int            due;
        logic [IDW-1:0] id;
        pres_t         r;
    } sb_t;
    typedef struct {
        logic            en;
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp;
    } arb_vec_t;

    logic                 clk = 1'b0;
    logic                 aclr, en, cnt_clr;
    logic [NREQ-1:0]      req_valid, req_ready, locked, lock_clr;
    logic [NREQ*WW-1:0]   req_data;
    logic                 pipe_dval, pipe_dval_out, pipe_cor, pipe_noncor, pipe_mal;
    logic [WW-1:0]        pipe_dig, pipe_out, rsp_data;
    logic [2*NDIG-1:0]    pipe_errdigs, rsp_errdigs;
    logic                 rsp_valid, busy, sync_err;
    logic [IDW-1:0]       rsp_id;
    logic [1:0]           rsp_status;
    logic [CNT_W-1:0]     cnt_cor, cnt_noncor, cnt_mal;

    int tests = 0, fails = 0, cyc = 0;
    bit sb_on = 0;
    logic [NREQ-1:0]  lock_clr_s = '0;
    logic             cnt_clr_s = 1'b0;
    sb_t              sbq[$];
    int               m_rr;
    logic [NREQ-1:0]  m_locked;
    int               m_bad [NREQ];
    logic [CNT_W-1:0] m_cor, m_noncor, m_mal;

    ec_pipe_sched #(.NREQ(NREQ), .IDW(IDW), .DATA_WIDTH(DW), .NDIG(NDIG), .PIPE_LAT(PIPE_LAT),
                    .LOCK_THRESH(TH), .CNT_W(CNT_W)) dut (
        .clk(clk), .aclr(aclr), .en(en), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .pipe_dval(pipe_dval), .pipe_dig(pipe_dig),
        .pipe_dval_out(pipe_dval_out), .pipe_out(pipe_out), .pipe_cor(pipe_cor),
        .pipe_noncor(pipe_noncor), .pipe_mal(pipe_mal), .pipe_errdigs(pipe_errdigs),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .rsp_errdigs(rsp_errdigs), .locked(locked), .lock_clr(lock_clr), .cnt_cor(cnt_cor),
        .cnt_noncor(cnt_noncor), .cnt_mal(cnt_mal), .cnt_clr(cnt_clr), .busy(busy), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic pres_t pfn(input logic [WW-1:0] w);
        pres_t r;
        int n;
        logic [1:0] code;
        n = 0;
        for (int d = 0; d < NDIG; d++) if (w[d*DW+DW-1]) n++;
        code = (n == 1) ? 2'b01 : (n == 2) ? 2'b10 : 2'b11;
        r.data = w;
        r.ed   = '0;
        r.n    = 4'(n);
        for (int d = 0; d < NDIG; d++) begin
            if (w[d*DW+DW-1]) begin
                r.ed[2*d +: 2] = code;
                if (n == 1) r.data[d*DW+DW-1] = 1'b0;
            end
        end
        r.st = (n == 0) ? 2'b00 : code;
        return r;
    endfunction

    function automatic logic [WW-1:0] cw();
        logic [WW-1:0] w;
        logic [31:0] r;
        w = '0;
        for (int d = 0; d < NDIG; d++) begin
            r = $urandom;
            w[d*DW +: DW-1] = r[DW-2:0];
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] bw(input int nb);
        logic [WW-1:0] w;
        w = cw();
        for (int d = 0; d < nb; d++) w[((d*3+1)%NDIG)*DW + DW-1] = 1'b1;
        return w;
    endfunction

    // Behavioural correction pipe: a plain delay line that is never reset.
    logic          pm_v   [PIPE_LAT] = '{default: 1'b0};
    logic [WW-1:0] pm_dat [PIPE_LAT] = '{default: '0};
    pres_t         tail_r;
    always @(posedge clk) begin
        for (int k = PIPE_LAT-1; k > 0; k--) begin
            pm_v[k]   <= pm_v[k-1];
            pm_dat[k] <= pm_dat[k-1];
        end
        pm_v[0]   <= pipe_dval;
        pm_dat[0] <= pipe_dig;
    end
    always_comb tail_r = pfn(pm_dat[PIPE_LAT-1]);
    assign pipe_dval_out = pm_v[PIPE_LAT-1];
    assign pipe_out      = tail_r.data;
    assign pipe_errdigs  = tail_r.ed;
    assign pipe_cor      = (tail_r.n != 4'd0);
    assign pipe_noncor   = (tail_r.n >= 4'd2);
    assign pipe_mal      = (tail_r.n >= 4'd3);

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        lock_clr_s = lock_clr;
        cnt_clr_s  = cnt_clr;
    end

    // Scoreboard and reference model, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin : mon
        sb_t e;
        int g;
        logic [NREQ-1:0] elig, exp_rdy;
        if (aclr) begin
            m_rr = 0; m_locked = '0; m_cor = '0; m_noncor = '0; m_mal = '0;
            for (int i = 0; i < NREQ; i++) m_bad[i] = 0;
            sbq.delete();
        end else if (sb_on) begin
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: id %0d arrived, expected no response", rsp_id);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.r.data);
                    chk("rsp_status", rsp_status, e.r.st);
                    chk("rsp_errdigs", rsp_errdigs, e.r.ed);
                    chk("rsp_latency", cyc, e.due);
                    chk("sync_err_quiet", sync_err, 0);
                    if (e.r.st[1]) begin
                        if (m_bad[e.id] < TH) m_bad[e.id]++;
                        if (m_bad[e.id] == TH) m_locked[e.id] = 1'b1;
                    end else begin
                        m_bad[e.id] = 0;
                    end
                    if (e.r.st == 2'b01 && m_cor != '1)    m_cor++;
                    if (e.r.st == 2'b10 && m_noncor != '1) m_noncor++;
                    if (e.r.st == 2'b11 && m_mal != '1)    m_mal++;
                end
            end
            for (int i = 0; i < NREQ; i++) if (lock_clr_s[i]) begin m_bad[i] = 0; m_locked[i] = 1'b0; end
            if (cnt_clr_s) begin m_cor = '0; m_noncor = '0; m_mal = '0; end
            if (rsp_valid || lock_clr_s != '0 || cnt_clr_s) begin
                chk("locked", locked, m_locked);
                chk("cnt_cor", cnt_cor, m_cor);
                chk("cnt_noncor", cnt_noncor, m_noncor);
                chk("cnt_mal", cnt_mal, m_mal);
            end
            elig = req_valid & ~m_locked & {NREQ{en}};
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && ((elig >> ((m_rr+k)%NREQ)) & NREQ'(1)) != '0) g = (m_rr+k)%NREQ;
            exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
            chk("req_ready_model", req_ready, exp_rdy);
            if (g >= 0) begin
                sbq.push_back('{due: cyc+PIPE_LAT+2, id: IDW'(g), r: pfn(req_data[g*WW +: WW])});
                m_rr = (g+1) % NREQ;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NREQ-1:0] v, input int nbad, input int cycles);
        req_valid = v;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NREQ; i++) req_data[i*WW +: WW] = (nbad == 0) ? cw() : bw(nbad);
            step();
        end
        req_valid = '0;
    endtask

    task automatic wait_rsp(input int n, input string nm);
        int seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk(nm, seen, n);
    endtask

    task automatic wait_pdo(input string nm);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (pipe_dval_out) hit = 1;
        end
        chk(nm, hit, 1);
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy && !rsp_valid && sbq.size() == 0) begin ok = 1; break; end
            step();
        end
        chk(nm, ok, 1);
    endtask

    arb_vec_t tab[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tab = '{'{1, 4'b1111, 4'b0001}, '{1, 4'b1111, 4'b0010}, '{1, 4'b1111, 4'b0100}, '{1, 4'b1111, 4'b1000},
                '{1, 4'b1111, 4'b0001}, '{1, 4'b1111, 4'b0010}, '{1, 4'b1111, 4'b0100}, '{1, 4'b1111, 4'b1000},
                '{1, 4'b1010, 4'b0010}, '{1, 4'b1010, 4'b1000}, '{0, 4'b1111, 4'b0000}, '{1, 4'b0000, 4'b0000},
                '{1, 4'b1001, 4'b0001}, '{1, 4'b1001, 4'b1000}, '{1, 4'b0100, 4'b0100}, '{1, 4'b0011, 4'b0001}};
        aclr = 1'b1; en = 1'b0; req_valid = '0; req_data = '0; lock_clr = '0; cnt_clr = 1'b0;
        repeat (3) step();
        chk("reset_ctrl", {pipe_dval, rsp_valid, busy, sync_err, locked, rsp_id, rsp_status}, 0);
        chk("reset_cnts", {cnt_cor, cnt_noncor, cnt_mal, rsp_errdigs}, 0);
        chk("reset_data", {pipe_dig, rsp_data} == 0, 1);
        aclr = 1'b0;
        step();
        sb_on = 1; en = 1'b1;

        for (int t = 0; t < 16; t++) begin
            en = tab[t].en;
            req_valid = tab[t].v;
            for (int i = 0; i < NREQ; i++) req_data[i*WW +: WW] = cw();
            #1;
            chk($sformatf("arb_vec%0d", t), req_ready, tab[t].exp);
            step();
        end
        req_valid = '0; en = 1'b1;
        wait_idle("arb_drain");

        issue(4'b0001, 0, 1);
        chk("single_pipe_dval", {pipe_dval, busy}, 2'b11);
        wait_rsp(1, "single_rsp");
        step();
        chk("single_busy_low", busy, 0);

        issue(4'b0100, 1, 1);
        issue(4'b1000, 3, 1);
        wait_idle("cor_mal_drain");
        chk("cnt_cor_one", cnt_cor, 1);
        chk("cnt_mal_one", cnt_mal, 1);

        issue(4'b0010, 2, 3);
        wait_rsp(2, "bad_rsp2");
        chk("not_locked_after_2", locked[1], 0);
        wait_rsp(1, "bad_rsp3");
        chk("locked_after_3", locked[1], 1);
        req_valid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NREQ; i++) req_data[i*WW +: WW] = cw();
            #1;
            chk("locked_no_grant", req_ready, 4'b0001);
            step();
        end
        req_valid = '0;
        wait_idle("lock_drain");
        lock_clr = 4'b0010;
        step();
        lock_clr = '0;
        chk("lock_clr_alone", locked, 0);

        issue(4'b0010, 2, 4);
        wait_rsp(3, "bad4_rsp3");
        chk("locked_before_clr", locked[1], 1);
        lock_clr = 4'b0010;
        step();
        lock_clr = '0;
        chk("lock_clr_vs_bad", {rsp_valid, locked[1]}, 2'b10);
        wait_idle("bad4_drain");
        issue(4'b0010, 2, 2);
        wait_idle("after_clr_drain");
        chk("bad_cnt_cleared", locked, 0);

        issue(4'b0001, 1, 15);
        wait_idle("sat_drain");
        chk("cnt_cor_sat", cnt_cor, 4'hF);
        issue(4'b0001, 1, 1);
        wait_idle("sat_hold_drain");
        chk("cnt_cor_sat_hold", cnt_cor, 4'hF);
        issue(4'b0001, 1, 1);
        wait_pdo("clr_pdo");
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr_vs_inc", {rsp_valid, cnt_cor, cnt_noncor, cnt_mal}, 13'h1000);
        wait_idle("clr_drain");

        issue(4'b1111, 0, 20);
        sb_on = 0;
        aclr = 1'b1;
        #1;
        chk("aclr_ctrl", {pipe_dval, busy, rsp_valid, sync_err, locked, rsp_id, rsp_status}, 0);
        chk("aclr_cnts", {cnt_cor, cnt_noncor, cnt_mal, rsp_errdigs}, 0);
        chk("aclr_data", {pipe_dig, rsp_data} == 0, 1);
        step();
        step();
        aclr = 1'b0;
        chk("sync_err_pre_stray", sync_err, 0);
        wait_pdo("stray_pdo");
        step();
        chk("sync_err_set", sync_err, 1);
        repeat (40) step();
        chk("sync_err_sticky", sync_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
